// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_t;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned COUNT_W    = DIGIT_W * NUM_DIGITS;

    localparam logic [COUNT_W-1:0] SW_MAX = 16'h9999;

    // True in the states where time advances.
    function automatic logic is_counting(input sw_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_controller_bcd_digit_counter.sv
// Single mod-10 BCD digit; carry is combinational so a chain of these
// ripples a full 09.99 -> 10.00 rollover within one clock edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    assign carry = inc && (q == DIGIT_W'(9));

    // Digit register: clear wins, otherwise step and wrap 9 -> 0.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= carry ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch core: button press detection, run/lap/pause/clear sequencing,
// centisecond prescaler and a 4-digit BCD SS.cc counter with lap freeze.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                button0,
    input  logic                button1,
    output logic [COUNT_W-1:0]  digits,
    output logic                running,
    output logic                lap_active,
    output logic                overflow
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    sw_state_t            state;
    logic                 button0_q;
    logic                 button1_q;
    logic                 press0;
    logic                 press1;
    logic                 counting;
    logic                 tick;
    logic                 clear_cmd;
    logic [PS_W-1:0]      prescaler;
    logic [COUNT_W-1:0]   count;
    logic [COUNT_W-1:0]   lap_reg;
    logic [NUM_DIGITS:0]  carry_chain;

    // Start/stop has priority: a simultaneous lap/clear press is discarded.
    assign press0    = button0 & ~button0_q;
    assign press1    = button1 & ~button1_q & ~press0;
    assign counting  = is_counting(state);
    assign tick      = counting && (prescaler == PS_LAST);
    assign clear_cmd = (state == PAUSE) && press1;

    // Edge-detect history; loading levels during reset masks held buttons.
    always_ff @(posedge clk) begin
        button0_q <= button0;
        button1_q <= button1;
    end

    // Prescaler advances only while counting and holds its phase in PAUSE.
    always_ff @(posedge clk) begin
        if (reset || clear_cmd) begin
            prescaler <= '0;
        end else if (counting) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    assign carry_chain[0] = tick;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (clear_cmd),
            .inc   (carry_chain[i]),
            .q     (count[i*DIGIT_W +: DIGIT_W]),
            .carry (carry_chain[i+1])
        );
    end

    // Carry out of the top digit is exactly the 99.99 -> 00.00 wrap.
    always_ff @(posedge clk) begin
        if (reset || clear_cmd) begin
            overflow <= 1'b0;
        end else if (carry_chain[NUM_DIGITS]) begin
            overflow <= 1'b1;
        end
    end

    // Control FSM with registered status flags and lap capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            lap_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press0) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        lap_active <= 1'b0;
                    end
                end
                RUN: begin
                    if (press0) begin
                        state      <= PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (press1) begin
                        state      <= LAP;
                        running    <= 1'b1;
                        lap_active <= 1'b1;
                        lap_reg    <= count;
                    end
                end
                LAP: begin
                    if (press0) begin
                        state      <= PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (press1) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        lap_active <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (press0) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        lap_active <= 1'b0;
                    end else if (press1) begin
                        state      <= IDLE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

    assign digits = lap_active ? lap_reg : count;

endmodule
